// File: rtl/sprite_compositor_if.sv
// Texel lookup bus between the compositor and the active animation frame memory.
// The memory answers combinationally from the address it is given.
interface sprite_compositor_if;
   logic [7:0]  ram_addr_x;
   logic [7:0]  ram_addr_y;
   logic [15:0] ram_data;

   modport master (
      output ram_addr_x,
      output ram_addr_y,
      input  ram_data
   );

   modport slave (
      input  ram_addr_x,
      input  ram_addr_y,
      output ram_data
   );
endinterface

// File: rtl/sprite_compositor.sv
// Two-stage pixel pipeline: raster counters -> texel address, then binary-alpha
// composite of the returned ARGB4444 texel over the background, syncs delayed to match.
module sprite_compositor #(
   parameter int SPR_W      = 128,
   parameter int SPR_H      = 128,
   parameter int LATCH_LINE = 480
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        pix_en,
   input  logic [9:0]                  h_cnt,
   input  logic [9:0]                  v_cnt,
   input  logic                        video_valid,
   input  logic                        hsync_in,
   input  logic                        vsync_in,
   input  logic [9:0]                  sprite_x,
   input  logic [9:0]                  sprite_y,
   input  logic [1:0]                  scale_sel,
   input  logic                        flip_x,
   input  logic [11:0]                 bg_rgb,
   sprite_compositor_if.master         mem,
   output logic [11:0]                 vga_rgb,
   output logic                        hsync_out,
   output logic                        vsync_out,
   output logic                        hit
);

   localparam logic [11:0] WIN_W_BASE = 12'(SPR_W);
   localparam logic [11:0] WIN_H_BASE = 12'(SPR_H);
   localparam logic [7:0]  TX_LAST    = 8'(SPR_W - 1);
   localparam logic [9:0]  LATCH_V    = 10'(LATCH_LINE);

   function automatic logic [1:0] shift_of_scale(input logic [1:0] sel);
      logic [1:0] sh;
      case (sel)
         2'd0:    sh = 2'd0;
         2'd1:    sh = 2'd1;
         default: sh = 2'd2;
      endcase
      return sh;
   endfunction

   logic [9:0]  sx_q, sx_d;
   logic [9:0]  sy_q, sy_d;
   logic [1:0]  ssc_q, ssc_d;
   logic        sflip_q, sflip_d;

   logic [7:0]  addr_x_q, addr_x_d;
   logic [7:0]  addr_y_q, addr_y_d;
   logic        in_win_q, in_win_d;
   logic        valid_q, valid_d;
   logic        hs_q, hs_d;
   logic        vs_q, vs_d;
   logic [11:0] bg_q, bg_d;

   logic [11:0] rgb_q, rgb_d;
   logic        hit_q, hit_d;
   logic        hso_q, hso_d;
   logic        vso_q, vso_d;

   logic        latch_s;
   logic [10:0] dx_s;
   logic [10:0] dy_s;
   logic [11:0] win_w_s;
   logic [11:0] win_h_s;
   logic        in_win_s;
   logic [7:0]  tx_s;
   logic [7:0]  ty_s;
   logic        opaque_s;

   // Shadow copy of position/scale/flip, refreshed only on the first blanking line.
   always_comb begin
      latch_s = pix_en && (h_cnt == 10'd0) && (v_cnt == LATCH_V);
      sx_d    = sx_q;
      sy_d    = sy_q;
      ssc_d   = ssc_q;
      sflip_d = sflip_q;
      if (latch_s) begin
         sx_d    = sprite_x;
         sy_d    = sprite_y;
         ssc_d   = shift_of_scale(scale_sel);
         sflip_d = flip_x;
      end else begin
         sx_d    = sx_q;
         sy_d    = sy_q;
         ssc_d   = ssc_q;
         sflip_d = sflip_q;
      end
   end

   // Stage 1: window test and texel address; 11/12-bit compares rule out wrap-around.
   always_comb begin
      dx_s     = {1'b0, h_cnt} - {1'b0, sx_q};
      dy_s     = {1'b0, v_cnt} - {1'b0, sy_q};
      win_w_s  = WIN_W_BASE << ssc_q;
      win_h_s  = WIN_H_BASE << ssc_q;
      in_win_s = video_valid
               && (h_cnt >= sx_q)
               && (v_cnt >= sy_q)
               && ({1'b0, dx_s} < win_w_s)
               && ({1'b0, dy_s} < win_h_s);
      tx_s     = 8'(dx_s >> ssc_q);
      ty_s     = 8'(dy_s >> ssc_q);

      addr_x_d = addr_x_q;
      addr_y_d = addr_y_q;
      in_win_d = in_win_q;
      valid_d  = valid_q;
      hs_d     = hs_q;
      vs_d     = vs_q;
      bg_d     = bg_q;
      if (pix_en) begin
         if (in_win_s) begin
            addr_x_d = sflip_q ? (TX_LAST - tx_s) : tx_s;
            addr_y_d = ty_s;
         end else begin
            addr_x_d = 8'd0;
            addr_y_d = 8'd0;
         end
         in_win_d = in_win_s;
         valid_d  = video_valid;
         hs_d     = hsync_in;
         vs_d     = vsync_in;
         bg_d     = bg_rgb;
      end else begin
         addr_x_d = addr_x_q;
         addr_y_d = addr_y_q;
      end
   end

   // Stage 2: any nonzero alpha nibble is fully opaque, zero is fully transparent.
   always_comb begin
      opaque_s = in_win_q && (mem.ram_data[15:12] != 4'd0);
      rgb_d    = rgb_q;
      hit_d    = hit_q;
      hso_d    = hso_q;
      vso_d    = vso_q;
      if (pix_en) begin
         if (!valid_q) begin
            rgb_d = 12'd0;
            hit_d = 1'b0;
         end else if (opaque_s) begin
            rgb_d = mem.ram_data[11:0];
            hit_d = 1'b1;
         end else begin
            rgb_d = bg_q;
            hit_d = 1'b0;
         end
         hso_d = hs_q;
         vso_d = vs_q;
      end else begin
         rgb_d = rgb_q;
         hit_d = hit_q;
      end
   end

   // Shadow registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sx_q    <= 10'd0;
         sy_q    <= 10'd0;
         ssc_q   <= 2'd0;
         sflip_q <= 1'b0;
      end else begin
         sx_q    <= sx_d;
         sy_q    <= sy_d;
         ssc_q   <= ssc_d;
         sflip_q <= sflip_d;
      end
   end

   // Stage 1 registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_x_q <= 8'd0;
         addr_y_q <= 8'd0;
         in_win_q <= 1'b0;
         valid_q  <= 1'b0;
         hs_q     <= 1'b0;
         vs_q     <= 1'b0;
         bg_q     <= 12'd0;
      end else begin
         addr_x_q <= addr_x_d;
         addr_y_q <= addr_y_d;
         in_win_q <= in_win_d;
         valid_q  <= valid_d;
         hs_q     <= hs_d;
         vs_q     <= vs_d;
         bg_q     <= bg_d;
      end
   end

   // Stage 2 (output) registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rgb_q <= 12'd0;
         hit_q <= 1'b0;
         hso_q <= 1'b0;
         vso_q <= 1'b0;
      end else begin
         rgb_q <= rgb_d;
         hit_q <= hit_d;
         hso_q <= hso_d;
         vso_q <= vso_d;
      end
   end

   assign mem.ram_addr_x = addr_x_q;
   assign mem.ram_addr_y = addr_y_q;
   assign vga_rgb        = rgb_q;
   assign hit            = hit_q;
   assign hsync_out      = hso_q;
   assign vsync_out      = vso_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Randomised bench for sprite_compositor against a per-pixel window/texel reference model.
module tb_sprite_compositor;
   localparam int SPR_W = 128;
   localparam int SPR_H = 128;
   localparam int LATCH = 480;

   logic        clk = 1'b0;
   logic        rst;
   logic        pix_en;
   logic [9:0]  h_cnt, v_cnt;
   logic        video_valid, hsync_in, vsync_in;
   logic [9:0]  sprite_x, sprite_y;
   logic [1:0]  scale_sel;
   logic        flip_x;
   logic [11:0] bg_rgb;
   logic [11:0] vga_rgb;
   logic        hsync_out, vsync_out, hit;
   int          mem_mode;
   int          n_checks = 0;
   int          n_errors = 0;

   typedef struct {
      bit valid;
      bit win;
      int ax;
      int ay;
      int bg;
      bit hs;
      bit vs;
   } pend_t;

   pend_t prev;
   int    m_sx, m_sy, m_f;
   bit    m_flip;

   sprite_compositor_if mif();

   sprite_compositor #(.SPR_W(SPR_W), .SPR_H(SPR_H), .LATCH_LINE(LATCH)) dut (
      .clk         (clk),
      .rst         (rst),
      .pix_en      (pix_en),
      .h_cnt       (h_cnt),
      .v_cnt       (v_cnt),
      .video_valid (video_valid),
      .hsync_in    (hsync_in),
      .vsync_in    (vsync_in),
      .sprite_x    (sprite_x),
      .sprite_y    (sprite_y),
      .scale_sel   (scale_sel),
      .flip_x      (flip_x),
      .bg_rgb      (bg_rgb),
      .mem         (mif.master),
      .vga_rgb     (vga_rgb),
      .hsync_out   (hsync_out),
      .vsync_out   (vsync_out),
      .hit         (hit)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] mem_fn(input logic [7:0] ax, input logic [7:0] ay, input int mode);
      logic [3:0]  a;
      logic [11:0] c;
      case (mode)
         1:       return 16'h0ABC;
         2:       return 16'hFABC;
         default: begin
            c = {ax[3:0] ^ ay[7:4], ax[7:4] + ay[3:0], ax[3:0] ^ 4'h5};
            a = (((int'(ax) + int'(ay)) % 3) == 0) ? 4'h0 : (ax[7:4] | 4'h1);
            return {a, c};
         end
      endcase
   endfunction

   assign mif.ram_data = mem_fn(mif.ram_addr_x, mif.ram_addr_y, mem_mode);

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_sx   = 0;
      m_sy   = 0;
      m_f    = 1;
      m_flip = 1'b0;
      prev   = '{valid: 1'b0, win: 1'b0, ax: 0, ay: 0, bg: 0, hs: 1'b0, vs: 1'b0};
   endtask

   // One pixel strobe: model the pixel, clock it in, check outputs of the previous pixel.
   task automatic strobe(input int h, input int v, input bit vv);
      pend_t       cur;
      logic [15:0] d;
      int          col, er, idle;
      bit          eh;
      logic [11:0] held_rgb;
      logic [7:0]  held_ax;
      h_cnt       = 10'(h);
      v_cnt       = 10'(v);
      video_valid = vv;
      hsync_in    = 1'($urandom);
      vsync_in    = 1'($urandom);
      bg_rgb      = 12'($urandom);
      cur.valid = vv;
      cur.hs    = hsync_in;
      cur.vs    = vsync_in;
      cur.bg    = int'(bg_rgb);
      cur.win   = vv && (h >= m_sx) && (v >= m_sy) && (h < m_sx + SPR_W * m_f) && (v < m_sy + SPR_H * m_f);
      if (cur.win) begin
         col    = (h - m_sx) / m_f;
         cur.ax = m_flip ? (SPR_W - 1 - col) : col;
         cur.ay = (v - m_sy) / m_f;
      end else begin
         cur.ax = 0;
         cur.ay = 0;
      end
      if (h == 0 && v == LATCH) begin
         m_sx   = int'(sprite_x);
         m_sy   = int'(sprite_y);
         m_f    = (scale_sel == 2'd0) ? 1 : (scale_sel == 2'd1) ? 2 : 4;
         m_flip = flip_x;
      end
      pix_en = 1'b1;
      @(posedge clk);
      #1;
      pix_en = 1'b0;
      if (!prev.valid) begin
         er = 0;
         eh = 1'b0;
      end else begin
         d = mem_fn(8'(prev.ax), 8'(prev.ay), mem_mode);
         if (prev.win && d[15:12] != 4'd0) begin
            er = int'(d[11:0]);
            eh = 1'b1;
         end else begin
            er = prev.bg;
            eh = 1'b0;
         end
      end
      check_val("vga_rgb", vga_rgb, er);
      check_val("hit", hit, eh);
      check_val("hsync_out", hsync_out, prev.hs);
      check_val("vsync_out", vsync_out, prev.vs);
      check_val("ram_addr_x", mif.ram_addr_x, cur.ax);
      check_val("ram_addr_y", mif.ram_addr_y, cur.ay);
      prev     = cur;
      held_rgb = vga_rgb;
      held_ax  = mif.ram_addr_x;
      idle     = $urandom_range(0, 2);
      repeat (idle) begin
         h_cnt       = 10'($urandom);
         v_cnt       = 10'($urandom);
         video_valid = 1'($urandom);
         @(posedge clk);
         #1;
      end
      if (idle > 0) begin
         check_val("hold_rgb", vga_rgb, held_rgb);
         check_val("hold_addr", mif.ram_addr_x, held_ax);
      end
   endtask

   task automatic do_latch(input int x, input int y, input int sc, input bit fl);
      sprite_x  = 10'(x);
      sprite_y  = 10'(y);
      scale_sel = 2'(sc);
      flip_x    = fl;
      strobe(0, LATCH, 1'b0);
   endtask

   initial begin
      int h, v;
      rst = 1'b0; pix_en = 1'b0; h_cnt = 10'd0; v_cnt = 10'd0; video_valid = 1'b0;
      hsync_in = 1'b0; vsync_in = 1'b0; sprite_x = 10'd0; sprite_y = 10'd0;
      scale_sel = 2'd0; flip_x = 1'b0; bg_rgb = 12'd0; mem_mode = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_rgb", vga_rgb, 12'd0);
      check_val("rst_hit", hit, 1'b0);
      check_val("rst_hs", hsync_out, 1'b0);
      check_val("rst_vs", vsync_out, 1'b0);
      check_val("rst_ax", mif.ram_addr_x, 8'd0);
      @(negedge clk);
      rst = 1'b1;

      // x1 at (100,50)
      do_latch(100, 50, 0, 1'b0);
      for (int i = 98; i <= 230; i++) begin
         strobe(i, 50, 1'b1);
         if (i == 100) check_val("x1_first", mif.ram_addr_x, 8'd0);
         if (i == 227) check_val("x1_last", mif.ram_addr_x, 8'd127);
         if (i == 228) check_val("x1_past", mif.ram_addr_x, 8'd0);
      end
      // x2, then x2 flipped
      do_latch(100, 50, 1, 1'b0);
      for (int i = 98; i <= 358; i++) begin
         strobe(i, 60, 1'b1);
         if (i == 355) check_val("x2_last", mif.ram_addr_x, 8'd127);
         if (i == 356) check_val("x2_past", mif.ram_addr_x, 8'd0);
      end
      do_latch(100, 50, 1, 1'b1);
      for (int i = 98; i <= 358; i++) begin
         strobe(i, 61, 1'b1);
         if (i == 100) check_val("flip_first", mif.ram_addr_x, 8'd127);
         if (i == 355) check_val("flip_last", mif.ram_addr_x, 8'd0);
      end
      // alpha: transparent then opaque constant texels
      mem_mode = 1;
      strobe(120, 60, 1'b1);
      strobe(121, 60, 1'b1);
      check_val("alpha0_hit", hit, 1'b0);
      mem_mode = 2;
      strobe(122, 60, 1'b1);
      strobe(123, 60, 1'b1);
      check_val("alphaF_rgb", vga_rgb, 12'hABC);
      check_val("alphaF_hit", hit, 1'b1);
      mem_mode = 0;
      // right-edge clipping, no wrap onto next line
      do_latch(600, 50, 0, 1'b0);
      for (int i = 590; i <= 639; i++) strobe(i, 70, 1'b1);
      for (int i = 0; i <= 45; i++) strobe(i, 71, 1'b1);
      // mid-frame position change is ignored until the latch line
      sprite_x = 10'd300;
      for (int i = 295; i <= 330; i++) strobe(i, 72, 1'b1);
      strobe(0, LATCH, 1'b0);
      for (int i = 295; i <= 330; i++) strobe(i, 73, 1'b1);
      // random raster positions, occasional relatch and memory mode swap
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 19) == 0) begin
            do_latch($urandom_range(0, 700), $urandom_range(0, 500), $urandom_range(0, 3), 1'($urandom));
         end
         if ($urandom_range(0, 29) == 0) mem_mode = $urandom_range(0, 2);
         h = $urandom_range(0, 799);
         v = $urandom_range(0, 524);
         strobe(h, v, (h < 640) && (v < 480));
      end
      // asynchronous reset mid-line while an opaque pixel is showing
      mem_mode = 2;
      do_latch(100, 50, 0, 1'b0);
      strobe(100, 50, 1'b1);
      strobe(101, 50, 1'b1);
      check_val("pre_rst_hit", hit, 1'b1);
      #2;
      rst = 1'b0;
      #1;
      check_val("async_rgb", vga_rgb, 12'd0);
      check_val("async_hit", hit, 1'b0);
      check_val("async_hs", hsync_out, 1'b0);
      check_val("async_vs", vsync_out, 1'b0);
      check_val("async_ax", mif.ram_addr_x, 8'd0);
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      mem_mode = 0;
      for (int i = 0; i < 40; i++) strobe(i, 5, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
